cla16_pipe_adder: RTL

//  Pipelined 16-bit two-level carry-lookahead adder with valid/ready handshake.

---
 rtl/cla_pkg.sv | 36 +++
 rtl/block_carry_lookahead_unit.sv | 31 +++
 rtl/cla_gp_group4.sv | 27 ++
 rtl/cla16_pipe_adder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined 16-bit carry-lookahead adder.
//   CLA_GRP / CLA_NGRP : bits per lookahead group / number of groups
//   gp_t               : group generate/propagate pair
//   s1_reg_t           : contents of the first pipeline register
//   group_gp()         : 4-bit group generate/propagate from bit-level g/p
package cla_pkg;

  localparam int CLA_GRP   = 4;
  localparam int CLA_NGRP  = 4;
  localparam int CLA_W     = CLA_GRP * CLA_NGRP;
  localparam int CLA_TAG_W = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  typedef struct packed {
    logic [CLA_W-1:0]     a;
    logic [CLA_W-1:0]     b;
    logic                 cin;
    logic [CLA_TAG_W-1:0] tag;
    logic [CLA_W-1:0]     g;
    logic [CLA_W-1:0]     p;
    logic [CLA_NGRP-1:0]  grp_g;
    logic [CLA_NGRP-1:0]  grp_p;
  } s1_reg_t;

  function automatic gp_t group_gp(input logic [3:0] g, input logic [3:0] p);
    gp_t r;
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.p = &p;
    return r;
  endfunction

endpackage

// File: rtl/block_carry_lookahead_unit.sv
// 4-input carry-lookahead unit. Used both across groups (G/P inputs) and
// inside a group (bit g/p inputs); the structure is identical.
//   g, p   : generate / propagate of the four inputs
//   c0     : carry into position 0
//   c      : carries into positions 0..3 (c[0] = c0)
//   g_star : block generate
//   p_star : block propagate
module block_carry_lookahead_unit
  import cla_pkg::*;
(
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       c0,
  output logic [3:0] c,
  output logic       g_star,
  output logic       p_star
);

  gp_t gp;

  always_comb begin
    c[0]   = c0;
    c[1]   = g[0] | (p[0] & c0);
    c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    gp     = group_gp(g, p);
    g_star = gp.g;
    p_star = gp.p;
  end

endmodule

// File: rtl/cla_gp_group4.sv
// 4-bit generate/propagate slice (combinational).
//   a, b   : 4-bit operand slices
//   g, p   : bit generate (a&b) and propagate (a^b)
//   grp_g  : group generate  G
//   grp_p  : group propagate P
module cla_gp_group4
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] g,
  output logic [3:0] p,
  output logic       grp_g,
  output logic       grp_p
);

  gp_t gp;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    gp    = group_gp(g, p);
    grp_g = gp.g;
    grp_p = gp.p;
  end

endmodule

// File: rtl/cla16_pipe_adder.sv
// Pipelined 16-bit two-level carry-lookahead adder, 2-cycle latency,
// one add per cycle, valid/ready on both sides.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake
//   in_a, in_b, in_cin  : operands and carry-in
//   in_tag              : opaque tag returned with the result
//   out_valid/out_ready : result handshake
//   out_sum, out_cout   : A+B+cin (low 16 bits) and carry out C16
//   out_tag             : tag of this result
//   out_ovf             : signed overflow C16^C15, only when CLA16_OVF_FLAG_EN is defined
module cla16_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef CLA16_OVF_FLAG_EN
  output logic             out_ovf,
`endif
  output logic [TAG_W-1:0] out_tag
);

  if (WIDTH != CLA_W) begin : g_width_chk
    $error("cla16_pipe_adder: WIDTH must be 16");
  end
  if (TAG_W != CLA_TAG_W) begin : g_tag_chk
    $error("cla16_pipe_adder: TAG_W must match cla_pkg::CLA_TAG_W");
  end

  logic    vld_p1, vld_p2;
  logic    s1_adv, s2_adv;
  s1_reg_t s1_n, s1_p1;

  logic [CLA_W-1:0]    g_n, p_n;
  logic [CLA_NGRP-1:0] grp_g_n, grp_p_n;

  // A full output stage can still move if it retires this cycle, so a
  // full pipeline accepts and retires in the same cycle without a bubble.
  assign s2_adv    = !vld_p2 | out_ready;
  assign s1_adv    = !vld_p1 | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_p2;

  // ---- stage 1: bit and group generate/propagate ----
  for (genvar j = 0; j < CLA_NGRP; j++) begin : g_grp
    cla_gp_group4 u_gp (
      .a     (in_a[CLA_GRP*j +: CLA_GRP]),
      .b     (in_b[CLA_GRP*j +: CLA_GRP]),
      .g     (g_n[CLA_GRP*j +: CLA_GRP]),
      .p     (p_n[CLA_GRP*j +: CLA_GRP]),
      .grp_g (grp_g_n[j]),
      .grp_p (grp_p_n[j])
    );
  end

  always_comb begin
    s1_n       = '0;
    s1_n.a     = in_a;
    s1_n.b     = in_b;
    s1_n.cin   = in_cin;
    s1_n.tag   = in_tag;
    s1_n.g     = g_n;
    s1_n.p     = p_n;
    s1_n.grp_g = grp_g_n;
    s1_n.grp_p = grp_p_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      s1_p1  <= '0;
    end else if (s1_adv) begin
      vld_p1 <= in_valid;
      if (in_valid) s1_p1 <= s1_n;
    end
  end

  // ---- stage 2: carry resolution and sum ----
  logic [CLA_NGRP-1:0] grp_c;
  logic                lvl2_g_star, lvl2_p_star;
  logic [CLA_W-1:0]    c_n;
  logic [CLA_NGRP-1:0] bit_g_star_unused, bit_p_star_unused;
  logic [CLA_W-1:0]    sum_n;
  logic                cout_n;

  block_carry_lookahead_unit u_lvl2 (
    .g      (s1_p1.grp_g),
    .p      (s1_p1.grp_p),
    .c0     (s1_p1.cin),
    .c      (grp_c),
    .g_star (lvl2_g_star),
    .p_star (lvl2_p_star)
  );

  for (genvar j = 0; j < CLA_NGRP; j++) begin : g_bit
    block_carry_lookahead_unit u_bit (
      .g      (s1_p1.g[CLA_GRP*j +: CLA_GRP]),
      .p      (s1_p1.p[CLA_GRP*j +: CLA_GRP]),
      .c0     (grp_c[j]),
      .c      (c_n[CLA_GRP*j +: CLA_GRP]),
      .g_star (bit_g_star_unused[j]),
      .p_star (bit_p_star_unused[j])
    );
  end

  // a^b is the latched half-sum, identical to the registered p.
  assign sum_n  = s1_p1.a ^ s1_p1.b ^ c_n;
  assign cout_n = lvl2_g_star | (lvl2_p_star & s1_p1.cin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_tag  <= '0;
`ifdef CLA16_OVF_FLAG_EN
      out_ovf  <= 1'b0;
`endif
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        out_sum  <= sum_n;
        out_cout <= cout_n;
        out_tag  <= s1_p1.tag;
`ifdef CLA16_OVF_FLAG_EN
        out_ovf  <= cout_n ^ c_n[CLA_W-1];
`endif
      end
    end
  end

endmodule
